// File: rtl/sysu_counter_updown.sv
// Presettable synchronous up/down counter in the 74LS161/191 style, with an
// explicit modulus wrap and ENT/RCO cascading. Asynchronous active-high clear.
module sysu_counter_updown #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int Delay   = 0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             LD,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             RCO
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    // Delay exists only to match the gate-level library's interface; this model is zero-delay.
    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) || Delay < 0) begin : g_bad_params
        $error("sysu_counter_updown: illegal WIDTH/MODULUS/Delay combination");
    end

    logic count_en;
    assign count_en = ENP & ENT;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            Q <= '0;
        end else if (!LD) begin
            Q <= D;
        end else if (count_en) begin
            if (UD) begin
                // >= so an out-of-range load also wraps to zero on the next up count
                Q <= (Q >= MAX_COUNT) ? '0 : Q + WIDTH'(1);
            end else begin
                Q <= (Q == '0) ? MAX_COUNT : Q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        TC  = UD ? (Q == MAX_COUNT) : (Q == '0);
        RCO = TC & ENT;
    end

endmodule

// File: tb/tb_sysu_counter_updown.sv
// Self-checking bench for sysu_counter_updown: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_sysu_counter_updown;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WIDTH=4, MODULUS=16
    logic       clr_a = 1'b1, ld_a = 1'b1, enp_a = 1'b0, ent_a = 1'b0, ud_a = 1'b1;
    logic [3:0] d_a = '0, q_a;
    logic       tc_a, rco_a;

    // Instance B: WIDTH=4, MODULUS=10
    logic       clr_b = 1'b1, ld_b = 1'b1, enp_b = 1'b0, ent_b = 1'b0, ud_b = 1'b1;
    logic [3:0] d_b = '0, q_b;
    logic       tc_b, rco_b;

    // Instance C: mod-10 via external NAND of Q[3], Q[0] into LD
    logic       clr_c = 1'b1;
    logic [3:0] q_c;
    logic       tc_c, rco_c, ld_c;
    assign ld_c = ~(q_c[3] & q_c[0]);

    // Cascade: two 4-bit mod-16 stages
    logic       clr_k = 1'b1, enp_k = 1'b0;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, rco_lo, tc_hi, rco_hi;

    sysu_counter_updown #(.WIDTH(4), .MODULUS(16), .Delay(0)) u_a (
        .CLK(clk), .CLR(clr_a), .LD(ld_a), .ENP(enp_a), .ENT(ent_a), .UD(ud_a),
        .D(d_a), .Q(q_a), .TC(tc_a), .RCO(rco_a));

    sysu_counter_updown #(.WIDTH(4), .MODULUS(10), .Delay(0)) u_b (
        .CLK(clk), .CLR(clr_b), .LD(ld_b), .ENP(enp_b), .ENT(ent_b), .UD(ud_b),
        .D(d_b), .Q(q_b), .TC(tc_b), .RCO(rco_b));

    sysu_counter_updown #(.WIDTH(4), .MODULUS(16), .Delay(0)) u_c (
        .CLK(clk), .CLR(clr_c), .LD(ld_c), .ENP(1'b1), .ENT(1'b1), .UD(1'b1),
        .D(4'd0), .Q(q_c), .TC(tc_c), .RCO(rco_c));

    sysu_counter_updown #(.WIDTH(4), .MODULUS(16), .Delay(0)) u_lo (
        .CLK(clk), .CLR(clr_k), .LD(1'b1), .ENP(enp_k), .ENT(1'b1), .UD(1'b1),
        .D(4'd0), .Q(q_lo), .TC(tc_lo), .RCO(rco_lo));

    sysu_counter_updown #(.WIDTH(4), .MODULUS(16), .Delay(0)) u_hi (
        .CLK(clk), .CLR(clr_k), .LD(1'b1), .ENP(enp_k), .ENT(rco_lo), .UD(1'b1),
        .D(4'd0), .Q(q_hi), .TC(tc_hi), .RCO(rco_hi));

    // Reference model: next count from the behavioural rules, plain integer arithmetic.
    function automatic int model_next(int m, int modulus, bit ld, bit enp, bit ent, bit ud, int d);
        if (!ld)           return d;
        if (!(enp && ent)) return m;
        if (ud)            return (m + 1 < modulus) ? m + 1 : 0;
        if (m == 0)        return modulus - 1;
        return m - 1;
    endfunction

    function automatic bit model_tc(int m, int modulus, bit ud);
        return ud ? (m == modulus - 1) : (m == 0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick; tick;
        ud_a = 1'b1; ent_a = 1'b1; #1;
        checks++; if (q_a !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", q_a); end
        checks++; if (tc_a !== 1'b0 || rco_a !== 1'b0) begin errors++; $display("FAIL reset_tc_up: got tc=%b rco=%b want 0 0", tc_a, rco_a); end
        ud_a = 1'b0; #1;
        checks++; if (tc_a !== 1'b1 || rco_a !== 1'b1) begin errors++; $display("FAIL reset_tc_down: got tc=%b rco=%b want 1 1", tc_a, rco_a); end
        ud_a = 1'b1; enp_a = 1'b1;
        clr_a = 1'b0;
        repeat (9) tick;
        checks++; if (q_a !== 4'd9) begin errors++; $display("FAIL count_to_9: got %0d want 9", q_a); end
        #2 clr_a = 1'b1; #1;
        checks++; if (q_a !== 4'd0) begin errors++; $display("FAIL async_clear: got %0d want 0", q_a); end
        tick;
        clr_a = 1'b0;
        checks++; if (q_a !== 4'd0) begin errors++; $display("FAIL clr_release_edge: got %0d want 0", q_a); end
        tick;
        checks++; if (q_a !== 4'd1) begin errors++; $display("FAIL resume_count: got %0d want 1", q_a); end
    endtask

    task automatic test_up_wrap;
        ld_a = 1'b0; d_a = 4'd0; tick; ld_a = 1'b1;
        ud_a = 1'b1; enp_a = 1'b1; ent_a = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick;
            checks++; if (q_a !== 4'(i % 16)) begin errors++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q_a, i % 16); end
            checks++; if (tc_a !== (i % 16 == 15) || rco_a !== (i % 16 == 15)) begin
                errors++; $display("FAIL up_tc[%0d]: got tc=%b rco=%b at q=%0d", i, tc_a, rco_a, q_a); end
        end
        ld_a = 1'b0; d_a = 4'd15; tick; ld_a = 1'b1; ent_a = 1'b0; #1;
        checks++; if (tc_a !== 1'b1 || rco_a !== 1'b0) begin errors++; $display("FAIL ent_gate: got tc=%b rco=%b want 1 0", tc_a, rco_a); end
        tick;
        checks++; if (q_a !== 4'd15) begin errors++; $display("FAIL ent_hold: got %0d want 15", q_a); end
    endtask

    task automatic test_down_mod;
        ld_b = 1'b0; d_b = 4'd0; clr_b = 1'b0; tick; ld_b = 1'b1;
        ud_b = 1'b0; enp_b = 1'b1; ent_b = 1'b1; #1;
        checks++; if (tc_b !== 1'b1) begin errors++; $display("FAIL down_tc0: got %b want 1", tc_b); end
        for (int i = 1; i <= 10; i++) begin
            tick;
            checks++; if (q_b !== 4'((10 - i) % 10)) begin errors++; $display("FAIL down_q[%0d]: got %0d want %0d", i, q_b, (10 - i) % 10); end
            checks++; if (tc_b !== (i == 10)) begin errors++; $display("FAIL down_tc[%0d]: got %b at q=%0d", i, tc_b, q_b); end
        end
    endtask

    task automatic test_load_priority;
        ld_a = 1'b0; d_a = 4'hA; enp_a = 1'b0; ent_a = 1'b0; ud_a = 1'b0;
        tick;
        checks++; if (q_a !== 4'd10) begin errors++; $display("FAIL load_no_enable: got %0d want 10", q_a); end
        d_a = 4'h5; clr_a = 1'b1; #1;
        checks++; if (q_a !== 4'd0) begin errors++; $display("FAIL clr_over_load_async: got %0d want 0", q_a); end
        tick;
        checks++; if (q_a !== 4'd0) begin errors++; $display("FAIL clr_over_load_edge: got %0d want 0", q_a); end
        clr_a = 1'b0; enp_a = 1'b1; ent_a = 1'b1;
        tick;
        checks++; if (q_a !== 4'd5) begin errors++; $display("FAIL load_over_count: got %0d want 5", q_a); end
        ld_a = 1'b1;
    endtask

    task automatic test_oor_load;
        ld_b = 1'b0; d_b = 4'd12; enp_b = 1'b0; ud_b = 1'b1; tick; ld_b = 1'b1; #1;
        checks++; if (q_b !== 4'd12 || tc_b !== 1'b0) begin errors++; $display("FAIL oor_up_tc: got q=%0d tc=%b want 12 0", q_b, tc_b); end
        ud_b = 1'b0; #1;
        checks++; if (tc_b !== 1'b0) begin errors++; $display("FAIL oor_down_tc: got %b want 0", tc_b); end
        ud_b = 1'b1; enp_b = 1'b1; ent_b = 1'b1; tick;
        checks++; if (q_b !== 4'd0) begin errors++; $display("FAIL oor_up_wrap: got %0d want 0", q_b); end
        ld_b = 1'b0; d_b = 4'd12; tick; ld_b = 1'b1; ud_b = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++; if (q_b !== 4'(12 - i)) begin errors++; $display("FAIL oor_down[%0d]: got %0d want %0d", i, q_b, 12 - i); end
        end
    endtask

    task automatic test_mod_n;
        clr_c = 1'b1; #2 clr_c = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick;
            checks++; if (q_c !== 4'(i % 10)) begin errors++; $display("FAIL mod_n[%0d]: got %0d want %0d", i, q_c, i % 10); end
        end
    endtask

    task automatic test_cascade;
        int total = 0;
        clr_k = 1'b1; #2 clr_k = 1'b0;
        for (int i = 0; i < 300; i++) begin
            enp_k = ($urandom_range(0, 3) != 0);
            tick;
            if (enp_k) total = (total + 1) % 256;
            checks++; if ({q_hi, q_lo} !== 8'(total)) begin errors++; $display("FAIL cascade[%0d]: got %0d want %0d", i, {q_hi, q_lo}, total); end
            checks++; if (rco_hi !== (total == 255)) begin errors++; $display("FAIL cascade_rco[%0d]: got %b at %0d", i, rco_hi, total); end
        end
    endtask

    task automatic test_random;
        int m;
        clr_b = 1'b1; ld_b = 1'b1; tick; m = 0;
        for (int i = 0; i < 250; i++) begin
            clr_b = ($urandom_range(0, 19) == 0);
            ld_b  = ($urandom_range(0, 4) != 0);
            enp_b = ($urandom_range(0, 3) != 0);
            ent_b = ($urandom_range(0, 3) != 0);
            ud_b  = $urandom_range(0, 1);
            d_b   = 4'($urandom_range(0, 15));
            m = clr_b ? 0 : model_next(m, 10, ld_b, enp_b, ent_b, ud_b, int'(d_b));
            tick;
            checks++; if (q_b !== 4'(m)) begin errors++; $display("FAIL rand_q[%0d]: got %0d want %0d", i, q_b, m); end
            checks++; if (tc_b !== model_tc(m, 10, ud_b) || rco_b !== (model_tc(m, 10, ud_b) & ent_b)) begin
                errors++; $display("FAIL rand_tc[%0d]: got tc=%b rco=%b q=%0d ud=%b ent=%b", i, tc_b, rco_b, m, ud_b, ent_b); end
        end
        clr_b = 1'b0;
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_down_mod;
        test_load_priority;
        test_oor_load;
        test_mod_n;
        test_cascade;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
